// File: rtl/stft_frame_scheduler.sv
// Analysis-side frame scheduler: writes samples into a circular BRAM and, every hop,
// streams the latest FRAME_LEN samples to the FFT as a real-only complex frame.
module stft_frame_scheduler #(
  parameter int FRAME_LEN = 2048,
  parameter int HOP_LEN   = 512,
  parameter int BUF_AW    = 12,
  parameter int SMP_W     = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SMP_W-1:0]             sample_in,
  input  logic                         sample_in_valid,
  output logic                         buf_wr_en,
  output logic [BUF_AW-1:0]            buf_wr_addr,
  output logic [SMP_W-1:0]             buf_wr_data,
  output logic                         buf_rd_en,
  output logic [BUF_AW-1:0]            buf_rd_addr,
  input  logic [SMP_W-1:0]             buf_rd_data,
  output logic [2*SMP_W-1:0]           fft_data,
  output logic [$clog2(FRAME_LEN)-1:0] fft_user,
  output logic                         fft_valid,
  output logic                         fft_last,
  input  logic                         fft_ready,
  input  logic                         frame_done,
  output logic                         busy,
  output logic [15:0]                  drop_cnt,
  output logic [1:0]                   fsm_state
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int HOP_W = $clog2(HOP_LEN);
  localparam logic [IDX_W:0] FILL_FULL = (IDX_W+1)'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BUF_AW-1:0] wr_ptr;
  logic [BUF_AW-1:0] wr_ptr_next;
  logic [IDX_W:0]    fill;
  logic [IDX_W:0]    fill_next;
  logic [HOP_W-1:0]  hop_cnt;
  logic              pending;
  logic [BUF_AW-1:0] frame_base;
  logic [BUF_AW-1:0] rd_base;
  logic              hop_event;
  logic              start_frame;

  logic [IDX_W:0]    rd_idx;
  logic              rd_inflight;
  logic [IDX_W-1:0]  rd_tag;
  logic [SMP_W-1:0]  sk_data [2];
  logic [IDX_W-1:0]  sk_idx  [2];
  logic              sk_wsel;
  logic              sk_rsel;
  logic [1:0]        sk_cnt;
  logic [2:0]        sk_occ;
  logic              issue;
  logic              pop;

  assign buf_wr_en   = sample_in_valid;
  assign buf_wr_addr = wr_ptr;
  assign buf_wr_data = sample_in;

  assign wr_ptr_next = wr_ptr + BUF_AW'(1);
  assign fill_next   = (fill == FILL_FULL) ? fill : fill + (IDX_W+1)'(1);
  assign hop_event   = sample_in_valid && (hop_cnt == HOP_W'(HOP_LEN - 1)) &&
                       (fill_next == FILL_FULL);
  // The pending request is consumed this cycle, so a coincident hop re-arms it rather than dropping.
  assign start_frame = (state == IDLE) && pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      fill       <= '0;
      hop_cnt    <= '0;
      pending    <= 1'b0;
      frame_base <= '0;
      drop_cnt   <= '0;
    end else begin
      if (sample_in_valid) begin
        wr_ptr  <= wr_ptr_next;
        fill    <= fill_next;
        hop_cnt <= hop_cnt + HOP_W'(1);
      end
      if (hop_event && (!pending || start_frame)) begin
        pending    <= 1'b1;
        frame_base <= wr_ptr_next - BUF_AW'(FRAME_LEN);
      end else if (start_frame) begin
        pending <= 1'b0;
      end
      if (hop_event && pending && !start_frame && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Output handshake: a beat transfers on any cycle where fft_valid && fft_ready; while
  // fft_valid is high and fft_ready low, fft_data/user/last are held unchanged.
  assign fft_valid = (sk_cnt != 2'd0);
  assign fft_data  = {{SMP_W{1'b0}}, sk_data[sk_rsel]};
  assign fft_user  = sk_idx[sk_rsel];
  assign fft_last  = fft_valid && (fft_user == IDX_W'(FRAME_LEN - 1));
  assign pop       = fft_valid && fft_ready;

  // A new read may issue only if the skid buffer can still absorb it after in-flight data lands.
  assign sk_occ    = {1'b0, sk_cnt} + {2'b00, rd_inflight};
  assign issue     = (state == STREAM) && !rd_idx[IDX_W] && (sk_occ < (3'd2 + {2'b00, pop}));

  assign buf_rd_en   = issue;
  assign buf_rd_addr = rd_base + BUF_AW'(rd_idx[IDX_W-1:0]);
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rd_base     <= '0;
      rd_idx      <= '0;
      rd_inflight <= 1'b0;
      rd_tag      <= '0;
      sk_data[0]  <= '0;
      sk_data[1]  <= '0;
      sk_idx[0]   <= '0;
      sk_idx[1]   <= '0;
      sk_wsel     <= 1'b0;
      sk_rsel     <= 1'b0;
      sk_cnt      <= 2'd0;
    end else begin
      rd_inflight <= issue;
      if (issue) begin
        rd_tag <= rd_idx[IDX_W-1:0];
        rd_idx <= rd_idx + (IDX_W+1)'(1);
      end
      if (rd_inflight) begin
        sk_data[sk_wsel] <= buf_rd_data;
        sk_idx[sk_wsel]  <= rd_tag;
        sk_wsel          <= ~sk_wsel;
      end
      if (pop) begin
        sk_rsel <= ~sk_rsel;
      end
      case ({rd_inflight, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase

      case (state)
        IDLE: begin
          if (pending) begin
            state   <= STREAM;
            rd_idx  <= '0;
            rd_base <= frame_base;
          end
        end
        STREAM: begin
          if (pop && fft_last) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (frame_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
